config_bitstream_loader: RTL and testbench
==========================================

Name: config_bitstream_loader

Overview:
- Host-side driver for the serial configuration chain of the tile array.
- Accepts the bitstream as parallel words over a valid/ready stream and serialises each word MSB-first onto the chain's serial data input.
- Drives the chain's shift enable; asserts it only on cycles that carry a real configuration bit.
- Reports busy/done, so the top level can release the fabric once the last chain bit has been clocked in.

Parameters:
- WORD_WIDTH, 32, width of each input bitstream word.
- CHAIN_LENGTH, 36, total number of configuration bits in the chain (sum over all tiles).
- COUNT_WIDTH, 16, width of the internal bit counter; must satisfy 2^COUNT_WIDTH > CHAIN_LENGTH.

Ports:
- config_clock  input  1  configuration clock; the same clock that shifts the chain.
- config_nreset  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- word_data  input  WORD_WIDTH  bitstream word.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  loader accepts word_data this cycle.
- config_data_out  output  1  serial bit to the chain's config_in.
- config_enable_out  output  1  chain shift enable.
- busy  output  1  load in progress.
- done  output  1  last load completed; sticky until the next accepted start or reset.
- crc_error  output  1  CRC mismatch on last load; sticky like done.

Behaviour:
- Reset: one clock; config_nreset is asynchronous, active-low. Asserting it forces, regardless of state:
  - state=IDLE
  - config_enable_out=0, config_data_out=0, word_ready=0
  - busy=0, done=0, crc_error=0
  - bit counter=0
- Reset mid-load abandons the load. Chain contents are then undefined; the host must restart.
- Outputs config_data_out and config_enable_out are registered. The chain samples them on the next config_clock rising edge.
- State IDLE:
  - busy=0.
  - start=1 → LOAD; clear done and crc_error; counter=CHAIN_LENGTH.
  - start in any other state is ignored.
- State LOAD:
  - busy=1, word_ready=1, config_enable_out=0.
  - Handshake: a word transfers on a cycle where word_valid=1 and word_ready=1.
  - On transfer: latch the word into the shift register, set the per-word bit count to min(WORD_WIDTH, remaining), go to SHIFT.
  - word_valid=0 → remain in LOAD. The chain is stalled; no enable pulses occur.
- State SHIFT:
  - word_ready=0.
  - Each cycle: config_data_out=shift_reg[WORD_WIDTH-1], config_enable_out=1, shift left by 1, decrement the per-word count and the remaining-bit counter.
  - Remaining reaches 0 → DONE (or CRC_CHECK when CRC_CONFIG_LOADER_EN is defined).
  - Per-word count reaches 0 with remaining still nonzero → LOAD.
  - Minimum overhead: one LOAD cycle per word.
- Bit order:
  - The first bit shifted ends at chain bit CHAIN_LENGTH-1.
  - Word 0 bit WORD_WIDTH-1 is shifted first.
  - Final partial word: only its top (CHAIN_LENGTH mod WORD_WIDTH) bits are used; the low bits are ignored.
- State DONE:
  - Registered outputs deassert on the first DONE cycle.
  - done=1, busy=0, then → IDLE with done held.
- Boundary cases:
  - Total config_enable_out high cycles per load = CHAIN_LENGTH exactly.
  - CHAIN_LENGTH an exact multiple of WORD_WIDTH → no partial word.
  - No word is accepted after the last data word, except the CRC word when the optional feature is enabled.

Optional Feature:
- Macro: CRC_CONFIG_LOADER_EN.
- Defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) is updated with every shifted bit, in shift order.
  - After the last chain bit, state CRC_CHECK (busy=1, word_ready=1) accepts one more word.
  - Its bits [15:0] are compared with the CRC; mismatch → crc_error=1. Then → DONE.
- Not defined:
  - No CRC logic and no CRC_CHECK state.
  - crc_error is tied to 0.

Test Plan:
- CHAIN_LENGTH=36, WORD_WIDTH=32. start, then words 0xDEADBEEF and 0xA0000000 with word_valid held high → exactly 36 enable cycles; chain captures 0xDEADBEEFA; done=1, busy=0; config_out of the tail tile matches the first shifted bit.
- Same load with word_valid dropped for 5 cycles before word 1 → enable low for those 5 cycles; final chain value still 0xDEADBEEFA; still 36 enable cycles.
- start pulsed again in the middle of SHIFT → ignored; single load completes normally; done asserts once.
- config_nreset asserted on the 10th shift cycle → all outputs 0 immediately (asynchronously); state IDLE; a fresh start then loads 0x123456789 correctly.
- Macro defined: correct CRC word for 0xDEADBEEF/0xA0000000 → done=1, crc_error=0. CRC word with bit 0 flipped → done=1, crc_error=1.
- Back-to-back loads: second start one cycle after done → done clears, busy=1, second load completes.

Source files
------------

// File: rtl/config_bitstream_loader.sv
// config_bitstream_loader
// Host-side driver for the tile array's serial configuration chain. Words
// arrive over a valid/ready stream and are shifted MSB-first onto the chain.
// The chain shift enable is high only on cycles that carry a real
// configuration bit, so it is high for exactly CHAIN_LENGTH cycles per load.
// Optional feature macro: CRC_CONFIG_LOADER_EN. When it is defined, a
// CRC-16-CCITT runs over the shifted bits and is checked against one extra
// trailing word. When it is not defined, crc_error is tied low.
// All outputs are registered. They are computed from the next state, so the
// enable and data pair is high during SHIFT cycles and low from the first
// DONE cycle onward.

module config_bitstream_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 36,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data_out,
  output logic                  config_enable_out,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_error
);

  localparam logic [COUNT_WIDTH-1:0] WORD_BITS  = COUNT_WIDTH'(WORD_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] CHAIN_BITS = COUNT_WIDTH'(CHAIN_LENGTH);
  localparam logic [COUNT_WIDTH-1:0] ONE_C      = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] ZERO_C     = COUNT_WIDTH'(0);

`ifdef CRC_CONFIG_LOADER_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_DONE      = 3'd3,
    ST_CRC_CHECK = 3'd4
  } state_t;

  // Advances the CRC-16-CCITT (poly 0x1021) by one bit, MSB-first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                           input logic        bit_in);
    logic fb;
    fb       = crc_in[15] ^ bit_in;
    crc_step = {crc_in[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3
  } state_t;
`endif

  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  shift_q, shift_d;
  logic [COUNT_WIDTH-1:0] rem_q,   rem_d;    // chain bits not yet scheduled
  logic [COUNT_WIDTH-1:0] wcnt_q,  wcnt_d;   // bits left in the current word
  logic                   ready_q, ready_d;
  logic                   data_q,  data_d;
  logic                   en_q,    en_d;
  logic                   busy_q,  busy_d;
  logic                   done_q,  done_d;
  logic                   take_s;
  logic [COUNT_WIDTH-1:0] first_cnt_s;
`ifdef CRC_CONFIG_LOADER_EN
  logic [15:0]            crc_q,     crc_d;
  logic                   crc_err_q, crc_err_d;
`endif

  assign take_s      = word_valid & ready_q;
  // The final partial word contributes only the bits still owed to the chain.
  assign first_cnt_s = (rem_q >= WORD_BITS) ? WORD_BITS : rem_q;

  // Next-state and next-output logic. The first bit of a word is scheduled
  // on the transfer edge, so SHIFT cycles map one-to-one onto enable cycles.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    ready_d = 1'b0;
    data_d  = 1'b0;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef CRC_CONFIG_LOADER_EN
    crc_d     = crc_q;
    crc_err_d = crc_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
          rem_d   = CHAIN_BITS;
          wcnt_d  = ZERO_C;
          ready_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef CRC_CONFIG_LOADER_EN
          crc_d     = 16'hFFFF;
          crc_err_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        busy_d = 1'b1;
        if (take_s) begin
          state_d = ST_SHIFT;
          data_d  = word_data[WORD_WIDTH-1];
          en_d    = 1'b1;
          shift_d = word_data << 1;
          wcnt_d  = first_cnt_s - ONE_C;
          rem_d   = rem_q - ONE_C;
`ifdef CRC_CONFIG_LOADER_EN
          crc_d   = crc_step(crc_q, word_data[WORD_WIDTH-1]);
`endif
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (wcnt_q == ZERO_C) begin
          if (rem_q == ZERO_C) begin
`ifdef CRC_CONFIG_LOADER_EN
            state_d = ST_CRC_CHECK;
            ready_d = 1'b1;
`else
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = ST_LOAD;
            ready_d = 1'b1;
          end
        end else begin
          data_d  = shift_q[WORD_WIDTH-1];
          en_d    = 1'b1;
          shift_d = shift_q << 1;
          wcnt_d  = wcnt_q - ONE_C;
          rem_d   = rem_q - ONE_C;
`ifdef CRC_CONFIG_LOADER_EN
          crc_d   = crc_step(crc_q, shift_q[WORD_WIDTH-1]);
`endif
        end
      end
`ifdef CRC_CONFIG_LOADER_EN
      ST_CRC_CHECK: begin
        busy_d = 1'b1;
        if (take_s) begin
          crc_err_d = (word_data[15:0] != crc_q);
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; asynchronous reset abandons any load.
  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      rem_q     <= ZERO_C;
      wcnt_q    <= ZERO_C;
      ready_q   <= 1'b0;
      data_q    <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CRC_CONFIG_LOADER_EN
      crc_q     <= 16'hFFFF;
      crc_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rem_q     <= rem_d;
      wcnt_q    <= wcnt_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CRC_CONFIG_LOADER_EN
      crc_q     <= crc_d;
      crc_err_q <= crc_err_d;
`endif
    end
  end

  assign word_ready        = ready_q;
  assign config_data_out   = data_q;
  assign config_enable_out = en_q;
  assign busy              = busy_q;
  assign done              = done_q;
`ifdef CRC_CONFIG_LOADER_EN
  assign crc_error         = crc_err_q;
`else
  assign crc_error         = 1'b0;
`endif

endmodule

// File: tb/tb_config_bitstream_loader.sv
// Directed bench for config_bitstream_loader (WORD_WIDTH=32, CHAIN_LENGTH=36).
// A behavioural 36-bit chain shifts on every clock edge where the enable is
// high. Expected chain images are hand-derived constants.
module tb_config_bitstream_loader;

  logic        config_clock = 1'b0;
  logic        config_nreset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] word_data = 32'h0;
  logic        word_valid = 1'b0;
  logic        word_ready, config_data_out, config_enable_out;
  logic        busy, done, crc_error;

  int n_cmp = 0;
  int n_mis = 0;

  // Chain model and event counters
  logic [35:0] chain_q = 36'h0;
  int          en_cnt = 0;
  int          done_rises = 0;
  logic        done_prev = 1'b0;
  logic        model_clr = 1'b0;

  config_bitstream_loader #(
    .WORD_WIDTH(32), .CHAIN_LENGTH(36), .COUNT_WIDTH(16)
  ) dut (
    .config_clock(config_clock),
    .config_nreset(config_nreset),
    .start(start),
    .word_data(word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .config_data_out(config_data_out),
    .config_enable_out(config_enable_out),
    .busy(busy),
    .done(done),
    .crc_error(crc_error)
  );

  always #5 config_clock = ~config_clock;

  always @(posedge config_clock) begin
    if (model_clr) begin
      chain_q    <= 36'h0;
      en_cnt     <= 0;
      done_rises <= 0;
    end else begin
      if (config_enable_out) begin
        chain_q <= {chain_q[34:0], config_data_out};
        en_cnt  <= en_cnt + 1;
      end
      if (done && !done_prev) done_rises <= done_rises + 1;
    end
    done_prev <= done;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [35:0] bits);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 35; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic clr_model();
    @(negedge config_clock); model_clr = 1'b1;
    @(negedge config_clock); model_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge config_clock); start = 1'b1;
    @(negedge config_clock); start = 1'b0;
    check_val("start_ready", {63'h0, word_ready}, 64'h1);
    check_val("start_busy",  {63'h0, busy},       64'h1);
    check_val("start_done",  {63'h0, done},       64'h0);
  endtask

  // Presents a word at a negedge and returns at the negedge after it transfers.
  task automatic send_word(input logic [31:0] w, input bit drop);
    int cnt;
    cnt = 0;
    word_valid = 1'b1;
    word_data  = w;
    while (!word_ready && cnt < 200) begin
      @(negedge config_clock);
      cnt++;
    end
    if (cnt >= 200) check_val("ready_timeout", 64'(cnt), 64'd0);
    @(negedge config_clock);
    if (drop) word_valid = 1'b0;
  endtask

  task automatic wait_done();
    int cnt;
    cnt = 0;
    while (!done && cnt < 300) begin
      @(negedge config_clock);
      cnt++;
    end
    if (cnt >= 300) check_val("done_timeout", 64'(cnt), 64'd0);
  endtask

  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1,
                          input int gap, input bit mid_start, input bit bad_crc);
    int          en_base;
    int          gap_hi;
    int          cnt;
    logic [35:0] exp_chain;
    logic        exp_err;
    exp_chain = {w0, w1[31:28]};
    exp_err   = 1'b0;
    pulse_start();
    en_base = en_cnt;
    send_word(w0, (gap != 0) || mid_start);
    if (gap != 0) begin
      cnt = 0;
      while (!word_ready && cnt < 100) begin
        @(negedge config_clock);
        cnt++;
      end
      if (cnt >= 100) check_val("load_timeout", 64'(cnt), 64'd0);
      gap_hi = 0;
      repeat (gap) begin
        if (config_enable_out) gap_hi++;
        @(negedge config_clock);
      end
      check_val("gap_enable_low", 64'(gap_hi), 64'd0);
    end
    if (mid_start) begin
      repeat (5) @(negedge config_clock);
      start = 1'b1;
      @(negedge config_clock);
      start = 1'b0;
    end
    send_word(w1, 1'b1);
`ifdef CRC_CONFIG_LOADER_EN
    send_word({16'h0, crc_of(exp_chain) ^ {15'h0, bad_crc}}, 1'b1);
    exp_err = bad_crc;
`endif
    wait_done();
    check_val("chain_value", {28'h0, chain_q},       {28'h0, exp_chain});
    check_val("enable_cnt",  64'(en_cnt - en_base),  64'd36);
    check_val("tail_bit",    {63'h0, chain_q[35]},   {63'h0, w0[31]});
    check_val("done_set",    {63'h0, done},          64'h1);
    check_val("busy_clr",    {63'h0, busy},          64'h0);
    check_val("crc_error",   {63'h0, crc_error},     {63'h0, exp_err});
  endtask

  initial begin
    int k;
    int cnt;
    int ready_hi;

    // Reset state
    repeat (2) @(negedge config_clock);
    check_val("reset_outputs",
              {58'h0, word_ready, config_data_out, config_enable_out, busy, done, crc_error},
              64'h0);
    config_nreset = 1'b1;
    clr_model();

    // Basic load, valid held high across both words
    run_load(32'hDEADBEEF, 32'hA0000000, 0, 1'b0, 1'b0);
    // No further word is accepted once the load is complete
    word_valid = 1'b1;
    word_data  = 32'h55555555;
    ready_hi = 0;
    repeat (4) begin
      @(negedge config_clock);
      if (word_ready) ready_hi++;
    end
    word_valid = 1'b0;
    check_val("no_extra_word", 64'(ready_hi), 64'd0);
    check_val("no_extra_en",   64'(en_cnt),   64'd36);
    check_val("done_sticky",   {63'h0, done}, 64'h1);

    // Stall of 5 cycles before the second word
    clr_model();
    run_load(32'hDEADBEEF, 32'hA0000000, 5, 1'b0, 1'b0);

    // Start pulsed mid-SHIFT is ignored
    clr_model();
    run_load(32'hDEADBEEF, 32'hA0000000, 0, 1'b1, 1'b0);
    repeat (10) @(negedge config_clock);
    check_val("single_done_rise", 64'(done_rises), 64'd1);
    check_val("no_second_load",   64'(en_cnt),     64'd36);
    check_val("idle_busy",        {63'h0, busy},   64'h0);

    // Asynchronous reset on the 10th shift cycle
    clr_model();
    pulse_start();
    send_word(32'hDEADBEEF, 1'b1);
    k = 0;
    cnt = 0;
    while (k < 10 && cnt < 100) begin
      if (config_enable_out) k++;
      if (k < 10) begin
        @(negedge config_clock);
        cnt++;
      end
    end
    check_val("tenth_shift_seen", 64'(k), 64'd10);
    config_nreset = 1'b0;
    #1;
    check_val("async_reset_outputs",
              {58'h0, word_ready, config_data_out, config_enable_out, busy, done, crc_error},
              64'h0);
    repeat (2) @(negedge config_clock);
    check_val("reset_hold_outputs",
              {58'h0, word_ready, config_data_out, config_enable_out, busy, done, crc_error},
              64'h0);
    config_nreset = 1'b1;
    clr_model();
    run_load(32'h12345678, 32'h90000000, 0, 1'b0, 1'b0);

`ifdef CRC_CONFIG_LOADER_EN
    // CRC word with bit 0 flipped flags an error
    clr_model();
    run_load(32'hDEADBEEF, 32'hA0000000, 0, 1'b0, 1'b1);
`endif

    // Back-to-back loads: second start issued the cycle after done
    run_load(32'hDEADBEEF, 32'hA0000000, 0, 1'b0, 1'b0);
    run_load(32'h12345678, 32'h90000000, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
